// File: rtl/adder_host_pkg.sv
// adder_host_pkg: shared types and constants for the adder_host initiator.
//   adder_host_state_t : FSM state encoding
//   LOAD_CYCLES        : cycles tx_write is held so the responder's
//                        synchronised write register sees it
//   TIMEOUT_LIMIT      : watchdog terminal count (ADDER_HOST_TIMEOUT_EN builds)
package adder_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    STROBE,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } adder_host_state_t;

  localparam int LOAD_CYCLES   = 2;
  localparam int TIMEOUT_LIMIT = 15;

endpackage

// File: rtl/adder_host_byte_mux.sv
// adder_host_byte_mux: byte lane selection for the adder_host initiator.
// Ports:
//   idx         in  3      current byte lane
//   operand0/1  in  W      latched operands
//   addend0/1   out 8      operand byte at lane idx
//   wr_en       in  1      replace lane idx of the result with wr_byte
//   wr_byte     in  8      responder sum byte
//   result_cur  in  W      current assembled result
//   result_nxt  out W      result with the lane write applied
// Purely combinational; loops over lanes so that no part-select can run
// past the operand width for small BYTES.
module adder_host_byte_mux #(
  parameter int BYTES = 4
) (
  input  logic [2:0]         idx,
  input  logic [8*BYTES-1:0] operand0,
  input  logic [8*BYTES-1:0] operand1,
  output logic [7:0]         addend0,
  output logic [7:0]         addend1,
  input  logic               wr_en,
  input  logic [7:0]         wr_byte,
  input  logic [8*BYTES-1:0] result_cur,
  output logic [8*BYTES-1:0] result_nxt
);

  always_comb begin
    addend0    = '0;
    addend1    = '0;
    result_nxt = result_cur;
    for (int i = 0; i < BYTES; i++) begin
      if (idx == i[2:0]) begin
        addend0 = operand0[8*i +: 8];
        addend1 = operand1[8*i +: 8];
        if (wr_en) result_nxt[8*i +: 8] = wr_byte;
      end
    end
  end

endmodule

// File: rtl/adder_host.sv
// adder_host: initiator for the byte-wide carry-adder responder protocol.
// Splits one W-bit addition (W = 8*BYTES) into BYTES byte operations,
// LSB first, chaining the carry through the responder.
// Ports:
//   aclk, areset             clock, asynchronous active-high reset
//   rx_valid/tx_ready        upstream request handshake
//   rx_operand0/1, rx_carryflag  request operands and carry-in
//   tx_enable/tx_write/tx_strobe responder control
//   tx_carryflag, tx_addend0/1   responder operands for the current byte
//   rx_sum, rx_carry, rx_ready   responder result and idle status
//   tx_result, tx_result_carryflag, tx_result_zeroflag  final result
//   tx_done                  one-cycle pulse when the result updates
//   tx_error                 one-cycle watchdog abort pulse
// Build option: define ADDER_HOST_TIMEOUT_EN to add the responder watchdog;
// without it tx_error is tied low and the host waits indefinitely.
module adder_host
  import adder_host_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               rx_valid,
  input  logic [8*BYTES-1:0] rx_operand0,
  input  logic [8*BYTES-1:0] rx_operand1,
  input  logic               rx_carryflag,
  output logic               tx_ready,
  output logic               tx_enable,
  output logic               tx_write,
  output logic               tx_strobe,
  output logic               tx_carryflag,
  output logic [7:0]         tx_addend0,
  output logic [7:0]         tx_addend1,
  input  logic [7:0]         rx_sum,
  input  logic               rx_carry,
  input  logic               rx_ready,
  output logic [8*BYTES-1:0] tx_result,
  output logic               tx_result_carryflag,
  output logic               tx_result_zeroflag,
  output logic               tx_done,
  output logic               tx_error
);

  localparam int         W         = 8*BYTES;
  localparam logic [2:0] LAST_IDX  = 3'(BYTES-1);
  localparam logic [1:0] LAST_LOAD = 2'(LOAD_CYCLES-1);

  adder_host_state_t state;
  logic [1:0]        load_cnt;
  logic [2:0]        idx;
  logic [W-1:0]      op0_q;
  logic [W-1:0]      op1_q;
  logic [W-1:0]      result_q;
  logic [W-1:0]      result_nxt;
  logic              c;
  logic              byte_wr;

`ifdef ADDER_HOST_TIMEOUT_EN
  logic [3:0]        wdog;
`endif

  assign byte_wr = (state == WAIT_DONE) && rx_ready;

  adder_host_byte_mux #(.BYTES(BYTES)) u_byte_mux (
    .idx        (idx),
    .operand0   (op0_q),
    .operand1   (op1_q),
    .addend0    (tx_addend0),
    .addend1    (tx_addend1),
    .wr_en      (byte_wr),
    .wr_byte    (rx_sum),
    .result_cur (result_q),
    .result_nxt (result_nxt)
  );

  // Responder controls decode directly from the state register.
  assign tx_enable    = (state != IDLE) && (state != DONE);
  assign tx_write     = (state == LOAD);
  assign tx_strobe    = (state == STROBE);
  assign tx_carryflag = c;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state               <= IDLE;
      tx_ready            <= 1'b1;
      load_cnt            <= '0;
      idx                 <= '0;
      op0_q               <= '0;
      op1_q               <= '0;
      result_q            <= '0;
      c                   <= 1'b0;
      tx_result           <= '0;
      tx_result_carryflag <= 1'b0;
      tx_result_zeroflag  <= 1'b0;
      tx_done             <= 1'b0;
`ifdef ADDER_HOST_TIMEOUT_EN
      wdog                <= '0;
      tx_error            <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
`ifdef ADDER_HOST_TIMEOUT_EN
      tx_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // tx_ready re-arms one cycle after DONE or an abort.
          if (tx_ready && rx_valid) begin
            op0_q    <= rx_operand0;
            op1_q    <= rx_operand1;
            c        <= rx_carryflag;
            idx      <= '0;
            load_cnt <= '0;
            result_q <= '0;
            tx_ready <= 1'b0;
            state    <= LOAD;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_cnt == LAST_LOAD) begin
            load_cnt <= '0;
            state    <= SETTLE;
          end else begin
            load_cnt <= load_cnt + 2'd1;
          end
        end
        SETTLE: state <= STROBE;
        STROBE: begin
          state <= WAIT_BUSY;
`ifdef ADDER_HOST_TIMEOUT_EN
          wdog  <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (!rx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Carry is re-sampled every busy cycle; the last one wins.
          if (!rx_ready) begin
            c <= rx_carry;
          end else begin
            result_q <= result_nxt;
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= LOAD;
            end
          end
        end
        DONE: begin
          tx_done             <= 1'b1;
          tx_result           <= result_q;
          tx_result_carryflag <= c;
          tx_result_zeroflag  <= (result_q == '0);
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef ADDER_HOST_TIMEOUT_EN
      // Fires on the 15th cycle spent waiting and overrides any transition.
      if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
        if (wdog == 4'(TIMEOUT_LIMIT-1)) begin
          tx_error <= 1'b1;
          state    <= IDLE;
        end else begin
          wdog <= wdog + 4'd1;
        end
      end
`endif
    end
  end

`ifndef ADDER_HOST_TIMEOUT_EN
  assign tx_error = 1'b0;
`endif

endmodule

// File: tb/tb_adder_host.sv
// tb_adder_host: self-checking bench for adder_host (BYTES=4 and BYTES=1)
// with behavioural 4-cycle-busy responders and a result scoreboard.
module tb_adder_host;

  logic        aclk = 1'b0;
  logic        areset;
  int          cyc = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // BYTES=4 instance
  logic        rx_valid;
  logic [31:0] rx_operand0, rx_operand1;
  logic        rx_carryflag;
  logic        tx_ready, tx_enable, tx_write, tx_strobe, tx_carryflag;
  logic [7:0]  tx_addend0, tx_addend1;
  logic [7:0]  rx_sum;
  logic        rx_carry, rx_ready;
  logic [31:0] tx_result;
  logic        tx_result_carryflag, tx_result_zeroflag, tx_done, tx_error;

  // BYTES=1 instance
  logic        v_b1;
  logic [7:0]  op0_b1, op1_b1;
  logic        cin_b1;
  logic        rdy_b1, en_b1, wr_b1, stb_b1, cf_b1;
  logic [7:0]  ad0_b1, ad1_b1;
  logic [7:0]  sum_b1;
  logic        car_b1, rrdy_b1;
  logic [7:0]  res_b1;
  logic        rc_b1, rz_b1, done_b1, err_b1;

  logic        hang;

  adder_host #(.BYTES(4)) dut (
    .aclk(aclk), .areset(areset),
    .rx_valid(rx_valid), .rx_operand0(rx_operand0), .rx_operand1(rx_operand1),
    .rx_carryflag(rx_carryflag), .tx_ready(tx_ready), .tx_enable(tx_enable),
    .tx_write(tx_write), .tx_strobe(tx_strobe), .tx_carryflag(tx_carryflag),
    .tx_addend0(tx_addend0), .tx_addend1(tx_addend1),
    .rx_sum(rx_sum), .rx_carry(rx_carry), .rx_ready(rx_ready),
    .tx_result(tx_result), .tx_result_carryflag(tx_result_carryflag),
    .tx_result_zeroflag(tx_result_zeroflag), .tx_done(tx_done), .tx_error(tx_error)
  );

  adder_host #(.BYTES(1)) dut_b1 (
    .aclk(aclk), .areset(areset),
    .rx_valid(v_b1), .rx_operand0(op0_b1), .rx_operand1(op1_b1),
    .rx_carryflag(cin_b1), .tx_ready(rdy_b1), .tx_enable(en_b1),
    .tx_write(wr_b1), .tx_strobe(stb_b1), .tx_carryflag(cf_b1),
    .tx_addend0(ad0_b1), .tx_addend1(ad1_b1),
    .rx_sum(sum_b1), .rx_carry(car_b1), .rx_ready(rrdy_b1),
    .tx_result(res_b1), .tx_result_carryflag(rc_b1),
    .tx_result_zeroflag(rz_b1), .tx_done(done_b1), .tx_error(err_b1)
  );

  // Responder models: latch on write, go busy 4 cycles on strobe.
  logic [7:0] m_a0, m_a1, n_a0, n_a1;
  logic       m_cf, n_cf;
  logic [1:0] m_cnt, n_cnt;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_a0 <= '0; m_a1 <= '0; m_cf <= 1'b0; m_cnt <= '0;
      rx_ready <= 1'b1; rx_sum <= '0; rx_carry <= 1'b0;
    end else begin
      if (tx_write) begin
        m_a0 <= tx_addend0; m_a1 <= tx_addend1; m_cf <= tx_carryflag;
      end
      if (tx_strobe && rx_ready) begin
        {rx_carry, rx_sum} <= {1'b0, m_a0} + {1'b0, m_a1} + {8'd0, m_cf};
        rx_ready <= 1'b0;
        m_cnt    <= 2'd3;
      end else if (!rx_ready && !hang) begin
        if (m_cnt == 2'd0) rx_ready <= 1'b1;
        else               m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      n_a0 <= '0; n_a1 <= '0; n_cf <= 1'b0; n_cnt <= '0;
      rrdy_b1 <= 1'b1; sum_b1 <= '0; car_b1 <= 1'b0;
    end else begin
      if (wr_b1) begin
        n_a0 <= ad0_b1; n_a1 <= ad1_b1; n_cf <= cf_b1;
      end
      if (stb_b1 && rrdy_b1) begin
        {car_b1, sum_b1} <= {1'b0, n_a0} + {1'b0, n_a1} + {8'd0, n_cf};
        rrdy_b1 <= 1'b0;
        n_cnt   <= 2'd3;
      end else if (!rrdy_b1) begin
        if (n_cnt == 2'd0) rrdy_b1 <= 1'b1;
        else               n_cnt <= n_cnt - 2'd1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        z;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic abort_mode = 1'b0;
  int   err_cnt = 0;

  // Scoreboard: push on accept, pop and compare on tx_done.
  initial begin
    exp_t e;
    logic [32:0] s;
    forever begin
      @(negedge aclk);
      if (tx_error) err_cnt++;
      if (!areset && rx_valid && tx_ready && !abort_mode) begin
        s     = {1'b0, rx_operand0} + {1'b0, rx_operand1} + {32'd0, rx_carryflag};
        e.r   = s[31:0];
        e.c   = s[32];
        e.z   = (s[31:0] == 32'd0);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      if (tx_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", tx_result, e.r);
          check("carry", tx_result_carryflag, e.c);
          check("zero", tx_result_zeroflag, e.z);
          check("latency", cyc - e.acc, 37);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      output int acc);
    @(posedge aclk); #2;
    rx_valid = 1'b1; rx_operand0 = a; rx_operand1 = b; rx_carryflag = ci;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (tx_ready) begin acc = cyc + 1; break; end
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    @(posedge aclk); #2;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (sb.size() == 0 && tx_ready) begin ok = 1; break; end
    end
    if (!ok) check(tag, 0, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, tx_ready, 1);
    check({tag, "_ctrl"}, {tx_enable, tx_write, tx_strobe, tx_carryflag}, 0);
    check({tag, "_addends"}, {tx_addend0, tx_addend1}, 0);
    check({tag, "_result"}, {tx_result, tx_result_carryflag, tx_result_zeroflag}, 0);
    check({tag, "_pulses"}, {tx_done, tx_error}, 0);
  endtask

  task automatic run_b1(input logic [7:0] a, input logic [7:0] b, input logic ci);
    int acc1, d1;
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    @(posedge aclk); #2;
    v_b1 = 1'b1; op0_b1 = a; op1_b1 = b; cin_b1 = ci;
    acc1 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (rdy_b1) begin acc1 = cyc + 1; break; end
    end
    @(posedge aclk); #2;
    v_b1 = 1'b0;
    d1 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (done_b1) begin d1 = cyc; break; end
    end
    check("b1_latency", d1 - acc1, 10);
    check("b1_result", res_b1, s[7:0]);
    check("b1_carry", rc_b1, s[8]);
    check("b1_zero", rz_b1, (s[7:0] == 8'd0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int acc, a1, a2, errc;
    areset = 1'b1; hang = 1'b0;
    rx_valid = 1'b0; rx_operand0 = '0; rx_operand1 = '0; rx_carryflag = 1'b0;
    v_b1 = 1'b0; op0_b1 = '0; op1_b1 = '0; cin_b1 = 1'b0;
    repeat (3) @(negedge aclk);
    check_reset_outs("in_reset");
    check("b1_in_reset", {rdy_b1, en_b1, res_b1, rc_b1, rz_b1, done_b1}, {1'b1, 12'd0});
    @(posedge aclk); #2;
    areset = 1'b0;
    @(negedge aclk);
    check_reset_outs("after_reset");

    // Wrap to zero with carry-out, then carry-in propagation.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, acc);
    wait_idle("idle_t1");
    send(32'h1234_5678, 32'h1111_1111, 1'b1, acc);
    wait_idle("idle_t2");
    check("t2_result_direct", tx_result, 32'h2345_678A);

    // rx_valid held high across a busy operation with new operands.
    @(posedge aclk); #2;
    rx_valid = 1'b1; rx_operand0 = 32'h89AB_CDEF; rx_operand1 = 32'h7654_3210; rx_carryflag = 1'b1;
    a1 = -1; a2 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (tx_ready) begin a1 = cyc + 1; break; end
    end
    @(posedge aclk); #2;
    rx_operand0 = 32'hCAFE_BABE; rx_operand1 = 32'h0F0F_0F0F; rx_carryflag = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (tx_ready) begin a2 = cyc + 1; break; end
    end
    @(posedge aclk); #2;
    rx_valid = 1'b0;
    check("b2b_spacing", a2 - a1, 39);
    wait_idle("idle_t3");

    // Reset during WAIT_DONE of byte 2.
    abort_mode = 1'b1;
    send(32'hA5C3_B2E1, 32'h5A5A_5A5A, 1'b1, acc);
    for (int i = 0; i < 40 && cyc < acc + 25; i++) @(negedge aclk);
    check("mid_byte2_addend", tx_addend0, 8'hC3);
    check("mid_enable", {tx_enable, tx_write, tx_strobe}, 3'b100);
    areset = 1'b1;
    #1;
    check_reset_outs("mid_reset");
    sb.delete();
    @(posedge aclk); #2;
    areset = 1'b0;
    repeat (45) @(negedge aclk);
    abort_mode = 1'b0;
    send(32'h0000_0001, 32'h0000_0001, 1'b0, acc);
    wait_idle("idle_t4");
    check("t4_result_direct", tx_result, 32'h2);

    // Responder that never returns to idle.
    abort_mode = 1'b1;
    hang = 1'b1;
    send(32'h0102_0304, 32'h1020_3040, 1'b0, acc);
`ifdef ADDER_HOST_TIMEOUT_EN
    errc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      if (tx_error) begin errc = cyc; break; end
    end
    check("wdog_latency", errc - acc, 19);
    check("err_enable_low", tx_enable, 0);
    check("err_result_kept", tx_result, 32'h2);
    @(negedge aclk);
    check("err_pulse_width", tx_error, 0);
    check("err_ready", tx_ready, 1);
    @(posedge aclk); #2;
    hang = 1'b0;
    repeat (8) @(negedge aclk);
`else
    errc = 0;
    repeat (40) @(negedge aclk);
    check("stall_ready_low", tx_ready, 0);
    check("stall_enable", tx_enable, 1);
    check("stall_result_kept", tx_result, 32'h2);
    @(posedge aclk); #2;
    areset = 1'b1; hang = 1'b0;
    @(posedge aclk); #2;
    areset = 1'b0;
    repeat (3) @(negedge aclk);
    check("stall_recover_ready", tx_ready, 1);
`endif
    sb.delete();
    abort_mode = 1'b0;

    // Single-byte configuration.
    run_b1(8'h80, 8'h80, 1'b0);
    run_b1(8'h7F, 8'h00, 1'b1);

`ifdef ADDER_HOST_TIMEOUT_EN
    check("error_pulses", err_cnt, 1);
`else
    check("error_pulses", err_cnt, 0);
`endif
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
